// File: rtl/stream_kernel_n.sv
// NxN signed convolution kernel with double-buffered runtime coefficients.
// Three registered stages: multiply, reduce, round/shift/saturate.
module stream_kernel_n #(
  parameter int unsigned N         = 3,
  parameter int unsigned PRECISION = 16,
  parameter int unsigned COEF_W    = 8,
  parameter int unsigned SHIFT     = 0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  input  logic signed [PRECISION-1:0] buffer_in [N-1:0][N-1:0],
  input  logic                        coef_wr,
  input  logic [$clog2(N*N)-1:0]      coef_addr,
  input  logic signed [COEF_W-1:0]    coef_data,
  input  logic                        coef_commit,
  output logic                        out_valid,
  output logic signed [PRECISION-1:0] out,
  output logic [7:0]                  out_rounded
);

  localparam int unsigned NumTaps = N * N;
  localparam int unsigned ProdW   = PRECISION + COEF_W;
  localparam int unsigned SumW    = ProdW + $clog2(NumTaps);
  localparam int unsigned Centre  = (N / 2) * N + N / 2;

  localparam logic signed [COEF_W-1:0] UnitCoef  = COEF_W'(1 << SHIFT);
  localparam logic signed [SumW:0]     RoundBias = (SumW + 1)'((1 << SHIFT) >> 1);
  localparam logic signed [SumW:0]     SatMax    =
      {{(SumW + 2 - PRECISION){1'b0}}, {(PRECISION - 1){1'b1}}};
  localparam logic signed [SumW:0]     SatMin    =
      {{(SumW + 2 - PRECISION){1'b1}}, {(PRECISION - 1){1'b0}}};

  typedef logic signed [COEF_W-1:0] coef_t;

  coef_t shadow_q [NumTaps];
  coef_t shadow_d [NumTaps];
  coef_t active_q [NumTaps];
  coef_t active_d [NumTaps];

  logic signed [ProdW-1:0]     prod_q [NumTaps];
  logic signed [ProdW-1:0]     prod_d [NumTaps];
  logic signed [SumW-1:0]      sum_q, sum_d;
  logic signed [SumW:0]        biased, shifted;
  logic signed [PRECISION-1:0] out_q, out_d, sat;
  logic                        valid1_q, valid2_q, valid3_q;

  // A same-cycle write is folded into shadow_d first, so a commit copies it too.
  always_comb begin
    shadow_d = shadow_q;
    if (coef_wr && (32'(coef_addr) < NumTaps)) begin
      shadow_d[coef_addr] = coef_data;
    end
    if (coef_commit) begin
      active_d = shadow_d;
    end else begin
      active_d = active_q;
    end
  end

  always_comb begin
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        prod_d[r*N+c] = ProdW'(buffer_in[r][c]) * ProdW'(active_q[r*N+c]);
      end
    end
  end

  always_comb begin
    sum_d = '0;
    for (int i = 0; i < NumTaps; i++) begin
      sum_d = sum_d + SumW'(prod_q[i]);
    end
  end

  // Bias of half an LSB before the arithmetic shift rounds half toward +inf.
  always_comb begin
    biased  = (SumW + 1)'(sum_q) + RoundBias;
    shifted = biased >>> SHIFT;
    if (shifted > SatMax) begin
      sat = SatMax[PRECISION-1:0];
    end else if (shifted < SatMin) begin
      sat = SatMin[PRECISION-1:0];
    end else begin
      sat = shifted[PRECISION-1:0];
    end
    out_d = out_q;
    if (valid2_q) begin
      out_d = sat;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid1_q <= 1'b0;
      valid2_q <= 1'b0;
      valid3_q <= 1'b0;
      out_q    <= '0;
      for (int i = 0; i < NumTaps; i++) begin
        shadow_q[i] <= (i == int'(Centre)) ? UnitCoef : '0;
        active_q[i] <= (i == int'(Centre)) ? UnitCoef : '0;
      end
    end else begin
      valid1_q <= in_valid;
      valid2_q <= valid1_q;
      valid3_q <= valid2_q;
      out_q    <= out_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

  // Datapath registers carry no state of their own; the valid bits qualify them.
  always_ff @(posedge clk) begin
    prod_q <= prod_d;
    sum_q  <= sum_d;
  end

  always_comb begin
    if (out_q[PRECISION-1]) begin
      out_rounded = 8'h00;
    end else if (|out_q[PRECISION-2:8]) begin
      out_rounded = 8'hFF;
    end else begin
      out_rounded = out_q[7:0];
    end
  end

  assign out_valid = valid3_q;
  assign out       = out_q;

endmodule

// File: tb/tb_stream_kernel_n.sv
// Directed bench for stream_kernel_n: one SHIFT=0 and one SHIFT=3 instance share stimulus.
module tb_stream_kernel_n;

  logic clk = 1'b0;
  logic reset, in_valid, coef_wr, coef_commit;
  logic [3:0] coef_addr;
  logic signed [7:0] coef_data;
  logic signed [15:0] win [2:0][2:0];

  logic s0_valid, s3_valid;
  logic signed [15:0] s0_out, s3_out;
  logic [7:0] s0_rnd, s3_rnd;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stream_kernel_n #(.N(3), .PRECISION(16), .COEF_W(8), .SHIFT(0)) u_s0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .buffer_in(win),
    .coef_wr(coef_wr), .coef_addr(coef_addr), .coef_data(coef_data),
    .coef_commit(coef_commit), .out_valid(s0_valid), .out(s0_out), .out_rounded(s0_rnd)
  );

  stream_kernel_n #(.N(3), .PRECISION(16), .COEF_W(8), .SHIFT(3)) u_s3 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .buffer_in(win),
    .coef_wr(coef_wr), .coef_addr(coef_addr), .coef_data(coef_data),
    .coef_commit(coef_commit), .out_valid(s3_valid), .out(s3_out), .out_rounded(s3_rnd)
  );

  task automatic set_window(input logic signed [15:0] centre, input logic signed [15:0] other);
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        win[r][c] = other;
      end
    end
    win[1][1] = centre;
  endtask

  task automatic load_all(input logic signed [7:0] v);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      coef_wr = 1'b1; coef_addr = 4'(i); coef_data = v;
    end
    @(negedge clk);
    coef_wr = 1'b0; coef_commit = 1'b1;
    @(negedge clk);
    coef_commit = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0; coef_wr = 1'b0; coef_commit = 1'b0;
    coef_addr = '0; coef_data = '0; set_window(16'sd0, 16'sd0);
    @(negedge clk);
    reset = 1'b0;
    checks++; if (s0_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", s0_valid); end
    checks++; if (s0_out !== 16'sd0) begin errors++; $display("FAIL reset_out got=%0d exp=0", s0_out); end
    checks++; if (s0_rnd !== 8'd0) begin errors++; $display("FAIL reset_rnd got=%0d exp=0", s0_rnd); end
    checks++; if (s3_valid !== 1'b0) begin errors++; $display("FAIL reset_valid_s3 got=%0b exp=0", s3_valid); end
  endtask

  task automatic test_identity();
    @(negedge clk);
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        win[r][c] = 16'($urandom_range(0, 1000));
      end
    end
    win[1][1] = 16'sd100;
    in_valid = 1'b1;
    for (int cyc = 1; cyc <= 4; cyc++) begin
      @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if (s0_valid !== (cyc == 3)) begin
        errors++; $display("FAIL identity_valid cyc=%0d got=%0b exp=%0b", cyc, s0_valid, cyc == 3);
      end
      if (cyc == 3) begin
        checks++; if (s0_out !== 16'sd100) begin errors++; $display("FAIL identity_out got=%0d exp=100", s0_out); end
        checks++; if (s0_rnd !== 8'd100) begin errors++; $display("FAIL identity_rnd got=%0d exp=100", s0_rnd); end
        checks++; if (s3_out !== 16'sd100) begin errors++; $display("FAIL identity_s3_out got=%0d exp=100", s3_out); end
      end
    end
  endtask

  task automatic test_neg_clamp();
    @(negedge clk);
    set_window(-16'sd5, 16'sd7); in_valid = 1'b1;
    @(negedge clk);
    set_window(16'sd300, -16'sd9);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (s0_valid !== 1'b1) begin errors++; $display("FAIL neg_valid got=%0b exp=1", s0_valid); end
    checks++; if (s0_out !== -16'sd5) begin errors++; $display("FAIL neg_out got=%0d exp=-5", s0_out); end
    checks++; if (s0_rnd !== 8'd0) begin errors++; $display("FAIL neg_rnd got=%0d exp=0", s0_rnd); end
    @(negedge clk);
    checks++; if (s0_valid !== 1'b1) begin errors++; $display("FAIL clamp_valid got=%0b exp=1", s0_valid); end
    checks++; if (s0_out !== 16'sd300) begin errors++; $display("FAIL clamp_out got=%0d exp=300", s0_out); end
    checks++; if (s0_rnd !== 8'd255) begin errors++; $display("FAIL clamp_rnd got=%0d exp=255", s0_rnd); end
    @(negedge clk);
    checks++; if (s0_valid !== 1'b0) begin errors++; $display("FAIL clamp_gap got=%0b exp=0", s0_valid); end
    checks++; if (s0_out !== 16'sd300) begin errors++; $display("FAIL clamp_hold got=%0d exp=300", s0_out); end
  endtask

  task automatic test_box_blur();
    load_all(8'sd1);
    @(negedge clk);
    set_window(16'sd20, 16'sd20); in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (s3_valid !== 1'b1) begin errors++; $display("FAIL blur_valid got=%0b exp=1", s3_valid); end
    checks++; if (s3_out !== 16'sd23) begin errors++; $display("FAIL blur_s3_out got=%0d exp=23", s3_out); end
    checks++; if (s3_rnd !== 8'd23) begin errors++; $display("FAIL blur_s3_rnd got=%0d exp=23", s3_rnd); end
    checks++; if (s0_out !== 16'sd180) begin errors++; $display("FAIL blur_s0_out got=%0d exp=180", s0_out); end
  endtask

  task automatic test_saturation();
    load_all(8'sd127);
    @(negedge clk);
    set_window(16'sd32767, 16'sd32767); in_valid = 1'b1;
    @(negedge clk);
    set_window(-16'sd32768, -16'sd32768);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (s0_out !== 16'sd32767) begin errors++; $display("FAIL sat_pos got=%0d exp=32767", s0_out); end
    checks++; if (s0_rnd !== 8'd255) begin errors++; $display("FAIL sat_pos_rnd got=%0d exp=255", s0_rnd); end
    checks++; if (s3_out !== 16'sd32767) begin errors++; $display("FAIL sat_pos_s3 got=%0d exp=32767", s3_out); end
    @(negedge clk);
    checks++; if (s0_out !== -16'sd32768) begin errors++; $display("FAIL sat_neg got=%0d exp=-32768", s0_out); end
    checks++; if (s3_out !== -16'sd32768) begin errors++; $display("FAIL sat_neg_s3 got=%0d exp=-32768", s3_out); end
  endtask

  // Identity active bank, all-ones shadow; commit with a same-cycle centre write of 2.
  task automatic test_commit_timing();
    logic signed [15:0] exp0, exp3;
    test_reset();
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      coef_wr = 1'b1; coef_addr = 4'(i); coef_data = 8'sd1;
    end
    @(negedge clk);
    coef_addr = 4'd9; coef_data = 8'sd50;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      coef_wr = 1'b0; coef_commit = 1'b0;
      if (i >= 3) begin
        exp0 = (i - 3 <= 2) ? 16'sd10 : 16'sd28;
        exp3 = (i - 3 <= 2) ? 16'sd10 : 16'sd4;
        checks++; if (s0_valid !== 1'b1) begin errors++; $display("FAIL commit_valid w%0d got=%0b exp=1", i - 3, s0_valid); end
        checks++; if (s0_out !== exp0) begin errors++; $display("FAIL commit_out w%0d got=%0d exp=%0d", i - 3, s0_out, exp0); end
        checks++; if (s3_out !== exp3) begin errors++; $display("FAIL commit_s3 w%0d got=%0d exp=%0d", i - 3, s3_out, exp3); end
      end
      set_window(16'sd10, 16'sd1);
      in_valid = (i < 6);
      if (i == 2) begin
        coef_commit = 1'b1; coef_wr = 1'b1; coef_addr = 4'd4; coef_data = 8'sd2;
      end
    end
    @(negedge clk);
    in_valid = 1'b0; coef_commit = 1'b1;
    @(negedge clk);
    coef_commit = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (s0_out !== 16'sd28) begin errors++; $display("FAIL recommit_out got=%0d exp=28", s0_out); end
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      set_window(16'sd10, 16'sd1); in_valid = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++; if (s0_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got=%0b exp=0", s0_valid); end
    checks++; if (s0_out !== 16'sd0) begin errors++; $display("FAIL midrst_out got=%0d exp=0", s0_out); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (s0_valid !== 1'b0) begin errors++; $display("FAIL midrst_stale c%0d got=%0b exp=0", i, s0_valid); end
    end
    coef_commit = 1'b1;
    @(negedge clk);
    coef_commit = 1'b0; set_window(16'sd77, 16'sd3); in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (s0_out !== 16'sd77) begin errors++; $display("FAIL midrst_identity got=%0d exp=77", s0_out); end
    checks++; if (s3_out !== 16'sd77) begin errors++; $display("FAIL midrst_identity_s3 got=%0d exp=77", s3_out); end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; coef_wr = 1'b0; coef_commit = 1'b0;
    coef_addr = '0; coef_data = '0; set_window(16'sd0, 16'sd0);
    repeat (2) @(negedge clk);
    test_reset();
    test_identity();
    test_neg_clamp();
    test_box_blur();
    test_saturation();
    test_commit_timing();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
